// File: rtl/inst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_pkg
//  Description : Shared RV32I encoding definitions for the instruction
//                encoder/loader (and the matching decoder): instruction
//                format enum, base opcodes, canonical NOP and loader states.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_pkg;

    // Instruction format selector carried on in_type
    typedef enum logic [2:0] {
        INST_R  = 3'd0,
        INST_I  = 3'd1,
        INST_S  = 3'd2,
        INST_SB = 3'd3,
        INST_UJ = 3'd4,
        INST_U  = 3'd5
    } inst_t;

    // RV32I base opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0,x0,0 -- substituted for bundles with an unknown format
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Loader control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

    // Formats 6 and 7 are not defined
    function automatic logic is_legal_type(input logic [2:0] t);
        return (t <= 3'd5);
    endfunction

endpackage : inst_pkg
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fifo
//  Description : Synchronous FIFO with full/empty flags and a combinational
//                head output. A push is accepted while full when a pop
//                happens in the same cycle.
//  Revision    : 1.0 - initial release
//
//  Parameters  : DEPTH (power of 2, >= 2), WIDTH
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                push_i/wdata_i - write request and data
//                pop_i          - read request (ignored while empty)
//                rdata_o        - current head entry
//                full_o/empty_o - occupancy flags
// ============================================================================
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = pop_i && !w_empty;
    // When full, the slot being written is the head that leaves this cycle
    assign w_push  = push_i && (!w_full || w_pop);

    // Storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign rdata_o = r_mem[r_rd_ptr[c_AW-1:0]];
    assign full_o  = w_full;
    assign empty_o = w_empty;

endmodule : inst_fifo
`default_nettype wire

// File: rtl/inst_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_encoder_loader
//  Description : RV32I instruction encoder and program loader. Field bundles
//                are packed into 32-bit words, buffered in a FIFO and written
//                sequentially into instruction memory over an acknowledged
//                write port.
//  Revision    : 1.0 - initial release
//
//  Build option: INST_ENC_CHECKSUM_EN - adds checksum[31:0], the running XOR
//                of every acknowledged mem_wdata (cleared by rst and start).
//
//  Parameters  : FIFO_DEPTH, BASE_ADDR, MAX_WORDS
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                start              - begin a load session (IDLE only)
//                in_valid/in_ready  - bundle handshake, in_last ends session
//                in_type..in_imm    - instruction fields
//                mem_we/addr/wdata  - write request, held until mem_ack
//                mem_ack            - memory accepted the write
//                done               - one-cycle session-complete pulse
//                word_count         - words written this session (saturates)
//                err_type/err_align - sticky error flags, cleared by start
// ============================================================================
module inst_encoder_loader
    import inst_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MAX_WORDS  = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [2:0]                 in_type,
    input  logic [6:0]                 in_opcode,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [2:0]                 in_funct3,
    input  logic [6:0]                 in_funct7,
    input  logic [31:0]                in_imm,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_ack,
    output logic                       done,
    output logic [$clog2(MAX_WORDS):0] word_count,
    output logic                       err_type,
    output logic                       err_align
`ifdef INST_ENC_CHECKSUM_EN
    ,
    output logic [31:0]                checksum
`endif
);

    localparam int                c_WCW    = $clog2(MAX_WORDS) + 1;
    localparam int                c_IW     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [c_WCW-1:0]  c_WC_MAX = c_WCW'(MAX_WORDS);
    localparam logic [c_IW-1:0]   c_IDX_LAST = c_IW'(MAX_WORDS - 1);

    load_state_t r_state;
    load_state_t w_state_d;

    logic [31:0]      r_addr;
    logic [c_IW-1:0]  r_widx;     // write slot within the MAX_WORDS window
    logic [c_WCW-1:0] r_wcount;
    logic             r_err_type;
    logic             r_err_align;

    logic        w_hs;
    logic        w_start;
    logic        w_write;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [31:0] w_fifo_head;
    logic [31:0] w_word;
    logic        w_bad_type;
    logic        w_misalign;

    // ------------------------------------------------------------------
    // Field packing. Bit 0 of SB/UJ offsets has no slot in the encoding,
    // so a set bit is simply dropped and flagged.
    // ------------------------------------------------------------------
    always_comb begin
        w_word     = NOP_WORD;
        w_bad_type = 1'b0;
        w_misalign = 1'b0;
        case (inst_t'(in_type))
            INST_R:  w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            INST_I:  w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            INST_S:  w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:0], in_opcode};
            INST_SB: begin
                w_word     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
                w_misalign = in_imm[0];
            end
            INST_UJ: begin
                w_word     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                              in_rd, in_opcode};
                w_misalign = in_imm[0];
            end
            INST_U:  w_word = {in_imm[31:12], in_rd, in_opcode};
            default: begin
                w_word     = NOP_WORD;
                w_bad_type = !is_legal_type(in_type);
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        in_ready  = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = !w_fifo_full;
                if (in_valid && !w_fifo_full && in_last) begin
                    w_state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // An empty FIFO means mem_we is low, so nothing is in flight
                if (w_fifo_empty) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    assign w_hs    = in_valid && in_ready;
    assign w_start = start && (r_state == ST_IDLE);
    assign w_write = mem_we && mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // Write pointer, word counter and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= BASE_ADDR;
            r_widx      <= '0;
            r_wcount    <= '0;
            r_err_type  <= 1'b0;
            r_err_align <= 1'b0;
        end else if (w_start) begin
            r_addr      <= BASE_ADDR;
            r_widx      <= '0;
            r_wcount    <= '0;
            r_err_type  <= 1'b0;
            r_err_align <= 1'b0;
        end else begin
            if (w_write) begin
                if (r_widx == c_IDX_LAST) begin
                    r_widx <= '0;
                    r_addr <= BASE_ADDR;
                end else begin
                    r_widx <= r_widx + 1'b1;
                    r_addr <= r_addr + 32'd4;
                end
                if (r_wcount != c_WC_MAX) begin
                    r_wcount <= r_wcount + 1'b1;
                end
            end
            if (w_hs && w_bad_type) begin
                r_err_type <= 1'b1;
            end
            if (w_hs && w_misalign) begin
                r_err_align <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Encoded-word buffer
    // ------------------------------------------------------------------
    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_hs),
        .wdata_i (w_word),
        .pop_i   (w_write),
        .rdata_o (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign mem_we     = !w_fifo_empty;
    assign mem_wdata  = w_fifo_head;
    assign mem_addr   = r_addr;
    assign word_count = r_wcount;
    assign err_type   = r_err_type;
    assign err_align  = r_err_align;

`ifdef INST_ENC_CHECKSUM_EN
    logic [31:0] r_csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= '0;
        end else if (w_start) begin
            r_csum <= '0;
        end else if (w_write) begin
            r_csum <= r_csum ^ mem_wdata;
        end
    end

    assign checksum = r_csum;
`else
    // No checksum state in this build
`endif

endmodule : inst_encoder_loader
`default_nettype wire

// File: tb/tb_inst_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_encoder_loader
//  Description : Directed self-checking bench for inst_encoder_loader. A
//                second instance with MAX_WORDS=4 shares the stimulus and is
//                used for the address-wrap case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic [2:0]  in_type;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        mem_ack;

    logic        in_ready, mem_we, done, err_type, err_align;
    logic [31:0] mem_addr, mem_wdata;
    logic [8:0]  word_count;

    logic        in_ready_w, mem_we_w, done_w, err_type_w, err_align_w;
    logic [31:0] mem_addr_w, mem_wdata_w;
    logic [2:0]  word_count_w;
`ifdef INST_ENC_CHECKSUM_EN
    logic [31:0] checksum, checksum_w;
`endif

    always #5 clk = ~clk;

    inst_encoder_loader u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_type(in_type), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .done(done), .word_count(word_count), .err_type(err_type),
        .err_align(err_align)
`ifdef INST_ENC_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    inst_encoder_loader #(.MAX_WORDS(4)) u_dut_w (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_last(in_last), .in_type(in_type), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .mem_we(mem_we_w), .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w),
        .mem_ack(mem_ack), .done(done_w), .word_count(word_count_w), .err_type(err_type_w),
        .err_align(err_align_w)
`ifdef INST_ENC_CHECKSUM_EN
        , .checksum(checksum_w)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Write / done monitors (record what the DUTs present at each edge)
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    logic [31:0] wlog_addr [64];
    int n_log  = 0;
    int n_wlog = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        if (!rst && mem_we && mem_ack && n_log < 64) begin
            log_addr[n_log] = mem_addr;
            log_data[n_log] = mem_wdata;
            n_log++;
        end
        if (!rst && mem_we_w && mem_ack && n_wlog < 64) begin
            wlog_addr[n_wlog] = mem_addr_w;
            n_wlog++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic last);
        in_valid = 1'b1; in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) break;
            tick();
        end
        check("hs_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 100; k++) begin
            if (done) break;
            tick();
        end
        check("done_seen", done, 1'b1);
    endtask

    int base;
    int dc0;
    logic [31:0] exp_words [6];

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_type = '0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;
        in_funct7 = '0; in_imm = '0; mem_ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // ---- reset state
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_word_count", word_count, 32'd0);
        check("rst_err", {err_type, err_align}, 32'd0);

        // ---- main sequence, ack tied high
        mem_ack = 1'b1;
        exp_words[0] = 32'h002081B3; exp_words[1] = 32'h00500093;
        exp_words[2] = 32'h0020A423; exp_words[3] = 32'h00208463;
        exp_words[4] = 32'h123452B7; exp_words[5] = 32'h010000EF;
        base = n_log;
        dc0  = done_cnt;
        pulse_start();
        send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0);
        send(3'd5, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0);
        send(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b1);
        wait_done();
        check("main_word_count", word_count, 32'd6);
        check("main_nwrites", n_log - base, 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("main_addr%0d", i), log_addr[base+i], 32'(i * 4));
            check($sformatf("main_data%0d", i), log_data[base+i], exp_words[i]);
        end
`ifdef INST_ENC_CHECKSUM_EN
        check("main_checksum", checksum, exp_words[0] ^ exp_words[1] ^ exp_words[2] ^
                                         exp_words[3] ^ exp_words[4] ^ exp_words[5]);
`endif
        repeat (3) tick();
        check("main_done_once", done_cnt - dc0, 32'd1);
        check("main_idle_ready", in_ready, 1'b0);

        // ---- backpressure then illegal type
        mem_ack = 1'b0;
        base = n_log;
        pulse_start();
        check("bp_we_empty", mem_we, 1'b0);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        check("bp_first_latency", mem_we, 1'b1);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b0);
        check("bp_full_ready", in_ready, 1'b0);
        repeat (3) tick();
        check("bp_hold_we", mem_we, 1'b1);
        check("bp_hold_addr", mem_addr, 32'h0);
        check("bp_hold_data", mem_wdata, 32'h00100093);
        check("bp_no_count", word_count, 32'd0);
        mem_ack = 1'b1;
        send(3'd7, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        wait_done();
        check("bp_nwrites", n_log - base, 32'd5);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_addr%0d", i), log_addr[base+i], 32'(i * 4));
            check($sformatf("bp_data%0d", i), log_data[base+i],
                  ((i + 1) << 20) | 32'h93);
        end
        check("ill_data", log_data[base+4], 32'h00000013);
        check("ill_addr", log_addr[base+4], 32'h10);
        check("ill_err_type", err_type, 1'b1);
        repeat (3) tick();
        check("ill_err_sticky", err_type, 1'b1);

        // ---- misaligned branch offset
        base = n_log;
        pulse_start();
        check("mis_err_type_clr", err_type, 1'b0);
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd9, 1'b1);
        wait_done();
        check("mis_data", log_data[base], 32'h00208463);
        check("mis_err_align", err_align, 1'b1);
        check("mis_err_type", err_type, 1'b0);
        tick();

        // ---- wrap on the MAX_WORDS=4 instance
        base = n_wlog;
        pulse_start();
        for (int i = 1; i <= 5; i++) begin
            send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), i == 5);
        end
        wait_done();
        check("wrap_nwrites", n_wlog - base, 32'd5);
        check("wrap_addr3", wlog_addr[base+3], 32'hC);
        check("wrap_addr4", wlog_addr[base+4], 32'h0);
        check("wrap_word_count", word_count_w, 32'd4);
        check("nowrap_word_count", word_count, 32'd5);
        tick();

        // ---- reset mid-LOAD with writes stalled
        mem_ack = 1'b0;
        pulse_start();
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0);
        check("mid_we_before", mem_we, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_we_after", mem_we, 1'b0);
        check("mid_idle", in_ready, 1'b0);
        check("mid_addr", mem_addr, 32'h0);
        dc0 = done_cnt;
        mem_ack = 1'b1;
        repeat (4) tick();
        check("mid_no_done", done_cnt - dc0, 32'd0);
        check("ack_idle_ignored", word_count, 32'd0);
        check("mid_we_stays", mem_we, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_inst_encoder_loader
`default_nettype wire
